// File: rtl/alu_ve_pkg.sv
// rtl/alu_ve_pkg.sv - shared types and helpers for the vector-scalar ALU
package alu_ve_pkg;

   typedef enum logic [2:0] {
      F_BCAST = 3'b001,
      F_ADD   = 3'b010,
      F_SUB   = 3'b011,
      F_MUL   = 3'b100,
      F_DIV   = 3'b110
   } funct_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_DONE
   } state_e;

   function automatic logic funct_legal(input logic [2:0] f);
      case (f)
         F_BCAST, F_ADD, F_SUB, F_MUL, F_DIV: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_ve_lane.sv
// rtl/alu_ve_lane.sv - one lane: combinational BCAST/ADD/SUB/MUL and one restoring-divide step
module alu_ve_lane
   import alu_ve_pkg::*;
#(
   parameter int LANE_W   = 8,
   parameter int SCALAR_W = 21
) (
   input  logic [2:0]          funct,
   input  logic [LANE_W-1:0]   a,
   input  logic [SCALAR_W-1:0] b,
   output logic [LANE_W-1:0]   alu_res,
   input  logic [SCALAR_W:0]   rem_in,
   input  logic [LANE_W-1:0]   quo_in,
   output logic [SCALAR_W:0]   rem_out,
   output logic [LANE_W-1:0]   quo_out
);

   logic [LANE_W-1:0]   b_low;
   logic [SCALAR_W+1:0] rem_sh;
   logic                ge;

   // Results are truncated to LANE_W, so only the low scalar bits can reach them.
   assign b_low = b[LANE_W-1:0];

   always_comb begin
      alu_res = '0;
      case (funct)
         F_BCAST: alu_res = b_low;
         F_ADD:   alu_res = a + b_low;
         F_SUB:   alu_res = a - b_low;
         F_MUL:   alu_res = a * b_low;
         default: alu_res = '0;
      endcase
   end

   // quo_in starts as the dividend and shifts its bits into the remainder MSB-first.
   always_comb begin
      rem_sh  = {rem_in, quo_in[LANE_W-1]};
      ge      = (rem_sh >= {2'b00, b});
      rem_out = ge ? (rem_sh[SCALAR_W:0] - {1'b0, b}) : rem_sh[SCALAR_W:0];
      quo_out = {quo_in[LANE_W-2:0], ge};
   end

endmodule

// File: rtl/alu_ve_seq.sv
// rtl/alu_ve_seq.sv - sequential vector-scalar ALU with valid/ready handshakes and multi-cycle divide
module alu_ve_seq
   import alu_ve_pkg::*;
#(
   parameter int LANES    = 24,
   parameter int LANE_W   = 8,
   parameter int SCALAR_W = 21
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2:0]                funct,
   input  logic [LANES*LANE_W-1:0]   op1,
   input  logic [SCALAR_W-1:0]       op2,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*LANE_W-1:0]   result,
   output logic                      out_err
);

   localparam int VEC_W = LANES * LANE_W;
   localparam int REM_W = SCALAR_W + 1;
   localparam int CNT_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(LANE_W - 1);

   state_e               state, state_n;
   logic [CNT_W-1:0]     cnt;
   logic [SCALAR_W-1:0]  op2_q;
   logic [SCALAR_W-1:0]  lane_b;
   logic [VEC_W-1:0]     quo_q, quo_nx, alu_vec, result_q;
   logic [LANES*REM_W-1:0] rem_q, rem_nx;
   logic                 err_q;
   logic                 accept;
   logic                 is_div;

   assign accept   = in_valid & in_ready;
   assign is_div   = (funct == F_DIV);
   assign result   = result_q;
   assign out_err  = err_q;
   // During a divide the lanes must see the captured divisor, not the live input.
   assign lane_b   = (state == S_DIV) ? op2_q : op2;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      alu_ve_lane #(
         .LANE_W   (LANE_W),
         .SCALAR_W (SCALAR_W)
      ) u_lane (
         .funct   (funct),
         .a       (op1[i*LANE_W +: LANE_W]),
         .b       (lane_b),
         .alu_res (alu_vec[i*LANE_W +: LANE_W]),
         .rem_in  (rem_q[i*REM_W +: REM_W]),
         .quo_in  (quo_q[i*LANE_W +: LANE_W]),
         .rem_out (rem_nx[i*REM_W +: REM_W]),
         .quo_out (quo_nx[i*LANE_W +: LANE_W])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_n = is_div ? S_DIV : S_DONE;
            end
         end
         S_DIV: begin
            if (cnt == '0) begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         op2_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (is_div) begin
                     rem_q <= '0;
                     quo_q <= op1;
                     op2_q <= op2;
                     cnt   <= CNT_TOP;
                  end else begin
                     result_q <= alu_vec;
                     err_q    <= ~funct_legal(funct);
                  end
               end
            end
            S_DIV: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt   <= cnt - 1'b1;
               // A zero divisor naturally yields all-ones quotients; only the flag is added.
               if (cnt == '0) begin
                  result_q <= quo_nx;
                  err_q    <= (op2_q == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
